fifo_wr_arbiter: RTL and testbench

Write-side arbiter that shares the single write port of the asynchronous FIFO (`wdata`/`winc`, observed `wfull`) between NREQ requesters in the write clock domain. It grants the port to one requester at a time in round-robin order, for a burst bounded by BURST words or by the requester's last-word flag. Writes are throttled by `wfull`, so no word is lost or duplicated. The block sits between the write-domain producers and the FIFO top level, and runs entirely on `wclk`.

---
 rtl/fifo_wr_arbiter.sv | 122 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the single write port of an asynchronous FIFO
// between NREQ write-domain requesters. The port is granted round-robin for
// bursts of up to BURST words, or fewer if the owner flags its last word.
// The FIFO full flag throttles writes, so no word is lost or duplicated.
module fifo_wr_arbiter #(
    parameter int NREQ  = 4,
    parameter int DW    = 8,
    parameter int BURST = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW   = $clog2(BURST + 1)
) (
    input  logic               wclk,
    input  logic               wrst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    ack,
    input  logic               wfull,
    output logic [DW-1:0]      wdata,
    output logic               winc,
    output logic [IW-1:0]      grant_id,
    output logic               busy
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW:0]   scan_idx;
    logic [IW-1:0] pick;
    logic          pick_vld;
    logic [IW-1:0] owner_nxt;
    logic [CW-1:0] cnt_inc;
    logic          own_req;
    logic          own_last;
    logic          cnt_hit;
    logic          release_w;

    // Round-robin search: first requesting index at or above rr_ptr, wrapping.
    // The index is carried one bit wider so the wrap is an explicit modulo.
    always_comb begin
        pick     = rr_ptr_q;
        pick_vld = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (scan_idx >= (IW+1)'(NREQ)) begin
                scan_idx = scan_idx - (IW+1)'(NREQ);
            end
            if (!pick_vld && req[scan_idx[IW-1:0]]) begin
                pick     = scan_idx[IW-1:0];
                pick_vld = 1'b1;
            end
        end
    end

    assign own_req   = req[owner_q];
    assign own_last  = req_last[owner_q];
    assign owner_nxt = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign cnt_inc   = cnt_q + 1'b1;
    assign cnt_hit   = (cnt_inc == CW'(BURST));

    // The write strobe is combinational from state so reset or wfull stops it at once.
    assign winc  = (state_q == OWN) && own_req && !wfull;
    assign wdata = req_data[int'(owner_q)*DW +: DW];
    assign ack   = winc ? (NREQ'(1) << owner_q) : '0;

    // Release on an abandoned grant, or on an accepted last word / BURST-th word.
    assign release_w = (state_q == OWN) &&
                       (!own_req || (winc && (own_last || cnt_hit)));

    assign busy     = (state_q == OWN);
    assign grant_id = owner_q;

    // Next-state logic for grant, burst counter and round-robin pointer.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = OWN;
                    owner_d = pick;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (winc) begin
                    cnt_d = cnt_inc;
                end
                if (release_w) begin
                    state_d  = IDLE;
                    rr_ptr_d = owner_nxt;
                end
            end
        endcase
    end

    // Arbiter state registers; reset restarts arbitration from requester 0.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: behavioural producers feed per-requester
// word lists, and every write is logged for order, ack and grant checks.
module tb_fifo_wr_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 8;
    localparam int BURST = 4;
    localparam int IW    = 2;

    logic               wclk = 1'b0;
    logic               wrst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_last;
    logic [NREQ-1:0]    ack;
    logic               wfull;
    logic [DW-1:0]      wdata;
    logic               winc;
    logic [IW-1:0]      grant_id;
    logic               busy;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .req      (req),
        .req_data (req_data),
        .req_last (req_last),
        .ack      (ack),
        .wfull    (wfull),
        .wdata    (wdata),
        .winc     (winc),
        .grant_id (grant_id),
        .busy     (busy)
    );

    int total = 0;
    int bad   = 0;

    logic [DW-1:0]   words [NREQ][16];
    logic            lasts [NREQ][16];
    int              nw    [NREQ];
    int              pos   [NREQ];
    int              start [NREQ];
    int              full_lo, full_hi;
    logic [31:0]     winc_tr, busy_tr;
    logic [DW-1:0]   fifo_q[$];
    logic [NREQ-1:0] ack_q[$];
    int              grant_q[$];
    int              stray;
    logic [DW-1:0]   exp_d[$];
    logic [NREQ-1:0] exp_a[$];
    int              exp_g[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        winc_tr = '0;
        busy_tr = '0;
        fifo_q.delete();
        ack_q.delete();
        grant_q.delete();
        stray = 0;
    endtask

    task automatic clear_all();
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            nw[i]    = 0;
            pos[i]   = 0;
            start[i] = 0;
            for (int j = 0; j < 16; j++) begin
                words[i][j] = '0;
                lasts[i][j] = 1'b0;
            end
        end
        full_lo = 1000;
        full_hi = -1;
    endtask

    task automatic do_reset();
        req      = '0;
        req_data = '0;
        req_last = '0;
        wfull    = 1'b0;
        wrst_n   = 1'b0;
        repeat (2) @(posedge wclk);
        #1;
        wrst_n = 1'b1;
    endtask

    task automatic drive(input int k);
        for (int i = 0; i < NREQ; i++) begin
            req[i] = (k >= start[i]) && (pos[i] < nw[i]);
            if (pos[i] < nw[i]) begin
                req_data[i*DW +: DW] = words[i][pos[i]];
                req_last[i]          = lasts[i][pos[i]];
            end else begin
                req_data[i*DW +: DW] = '0;
                req_last[i]          = 1'b0;
            end
        end
        wfull = (k >= full_lo) && (k <= full_hi);
    endtask

    task automatic run(input int n);
        logic            busy_prev;
        logic [NREQ-1:0] ackd;
        busy_prev = 1'b0;
        for (int k = 0; k < n; k++) begin
            drive(k);
            @(negedge wclk);
            winc_tr = {winc_tr[30:0], winc};
            busy_tr = {busy_tr[30:0], busy};
            if (busy && !busy_prev) grant_q.push_back(int'(grant_id));
            busy_prev = busy;
            if (winc) begin
                fifo_q.push_back(wdata);
                ack_q.push_back(ack);
            end else if (ack != '0) begin
                stray++;
            end
            ackd = ack;
            @(posedge wclk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (ackd[i]) pos[i]++;
            end
        end
    endtask

    task automatic chk_fifo(input string tag);
        chk({tag, " len"}, 32'(fifo_q.size()), 32'(exp_d.size()));
        for (int i = 0; i < exp_d.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                (i < fifo_q.size()) ? 32'(fifo_q[i]) : 32'hFFFF_FFFF, 32'(exp_d[i]));
        end
    endtask

    task automatic chk_grants(input string tag);
        chk({tag, " len"}, 32'(grant_q.size()), 32'(exp_g.size()));
        for (int i = 0; i < exp_g.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                (i < grant_q.size()) ? 32'(grant_q[i]) : 32'hFFFF_FFFF, 32'(exp_g[i]));
        end
    endtask

    task automatic chk_acks(input string tag);
        chk({tag, " len"}, 32'(ack_q.size()), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                (i < ack_q.size()) ? 32'(ack_q[i]) : 32'hFFFF_FFFF, 32'(exp_a[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle
        clear_all();
        req = '0; req_data = '0; req_last = '0; wfull = 1'b0;
        wrst_n = 1'b0;
        #12;
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst winc", 32'(winc), 32'd0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge wclk);
            chk("idle winc", 32'(winc), 32'd0);
            chk("idle ack", 32'(ack), 32'd0);
            chk("idle busy", 32'(busy), 32'd0);
            chk("idle gid", 32'(grant_id), 32'd0);
        end

        // Single requester 2, six words, last on the sixth
        clear_all();
        do_reset();
        nw[2] = 6;
        for (int j = 0; j < 6; j++) words[2][j] = 8'h21 + 8'(j);
        lasts[2][5] = 1'b1;
        run(10);
        chk("s2 winc trace", winc_tr, 32'b0111101100);
        chk("s2 busy trace", busy_tr, 32'b0111101100);
        exp_d = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
        chk_fifo("s2 fifo");
        exp_g = '{2, 2};
        chk_grants("s2 grant");
        exp_a = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
        chk_acks("s2 ack");
        chk("s2 stray ack", 32'(stray), 32'd0);

        // Round robin, all four requesting one-word bursts
        clear_all();
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            nw[i] = 2;
            for (int j = 0; j < 2; j++) begin
                words[i][j] = 8'hA0 + 8'(i*16) + 8'(j);
                lasts[i][j] = 1'b1;
            end
        end
        run(17);
        chk("rr winc trace", winc_tr, 32'b01010101010101010);
        chk("rr busy trace", busy_tr, 32'b01010101010101010);
        exp_g = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk_grants("rr grant");
        exp_d = '{8'hA0, 8'hB0, 8'hC0, 8'hD0, 8'hA1, 8'hB1, 8'hC1, 8'hD1};
        chk_fifo("rr fifo");
        exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        chk_acks("rr ack");

        // Backpressure: owner 1, wfull for three cycles after two words
        clear_all();
        do_reset();
        nw[1] = 4;
        for (int j = 0; j < 4; j++) words[1][j] = 8'h51 + 8'(j);
        lasts[1][3] = 1'b1;
        full_lo = 3;
        full_hi = 5;
        run(10);
        chk("bp winc trace", winc_tr, 32'b0110001100);
        chk("bp busy trace", busy_tr, 32'b0111111100);
        exp_d = '{8'h51, 8'h52, 8'h53, 8'h54};
        chk_fifo("bp fifo");
        exp_g = '{1};
        chk_grants("bp grant");
        chk("bp stray ack", 32'(stray), 32'd0);

        // Abandon: owner 2 drops req after two words, then 3 beats 0
        clear_all();
        do_reset();
        nw[2] = 2; words[2][0] = 8'h31; words[2][1] = 8'h32;
        nw[3] = 1; words[3][0] = 8'h41; lasts[3][0] = 1'b1; start[3] = 3;
        nw[0] = 1; words[0][0] = 8'h11; lasts[0][0] = 1'b1; start[0] = 3;
        run(10);
        chk("ab winc trace", winc_tr, 32'b0110010100);
        chk("ab busy trace", busy_tr, 32'b0111010100);
        exp_g = '{2, 3, 0};
        chk_grants("ab grant");
        exp_d = '{8'h31, 8'h32, 8'h41, 8'h11};
        chk_fifo("ab fifo");

        // Reset in the middle of requester 3's burst
        clear_all();
        do_reset();
        nw[2] = 1; words[2][0] = 8'h71; lasts[2][0] = 1'b1;
        nw[3] = 4; start[3] = 3;
        for (int j = 0; j < 4; j++) words[3][j] = 8'h81 + 8'(j);
        nw[0] = 1; words[0][0] = 8'h61; lasts[0][0] = 1'b1; start[0] = 5;
        nw[1] = 1; words[1][0] = 8'h62; lasts[1][0] = 1'b1; start[1] = 5;
        run(6);
        chk("mr pre winc trace", winc_tr, 32'b010011);
        exp_g = '{2, 3};
        chk_grants("mr pre grant");
        drive(6);
        @(negedge wclk);
        chk("mr pre winc", 32'(winc), 32'd1);
        chk("mr pre wdata", 32'(wdata), 32'h83);
        chk("mr pre ack", 32'(ack), 32'b1000);
        #1;
        wrst_n = 1'b0;
        #1;
        chk("mr rst winc", 32'(winc), 32'd0);
        chk("mr rst ack", 32'(ack), 32'd0);
        chk("mr rst busy", 32'(busy), 32'd0);
        chk("mr rst gid", 32'(grant_id), 32'd0);
        @(posedge wclk);
        #1;
        wrst_n = 1'b1;
        clear_logs();
        for (int i = 0; i < NREQ; i++) start[i] = 0;
        run(9);
        chk("mr post winc trace", winc_tr, 32'b010101100);
        exp_g = '{0, 1, 3};
        chk_grants("mr post grant");
        exp_d = '{8'h61, 8'h62, 8'h83, 8'h84};
        chk_fifo("mr post fifo");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
